// File: rtl/avalon_mem_arbiter.sv
// rtl/avalon_mem_arbiter.sv - two-master shared memory port arbiter with 1-cycle read response routing
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise master 0 has fixed priority.
module avalon_mem_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_WIDTH-1:0]   m0_writedata,
    output logic                    m0_waitrequest,
    output logic [DATA_WIDTH-1:0]   m0_readdata,
    output logic                    m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_WIDTH-1:0]   m1_writedata,
    output logic                    m1_waitrequest,
    output logic [DATA_WIDTH-1:0]   m1_readdata,
    output logic                    m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0]   s_address,
    output logic [DATA_WIDTH/8-1:0] s_byteenable,
    output logic                    s_read,
    output logic                    s_write,
    output logic [DATA_WIDTH-1:0]   s_writedata,
    input  logic [DATA_WIDTH-1:0]   s_readdata
);

    logic req0;
    logic req1;
    logic grant_valid;
    logic grant_id;
    logic last_grant;
    logic tag_valid;
    logic tag_id;
    logic sel_read;
    logic sel_write;

    always_comb begin
        req0        = m0_read | m0_write;
        req1        = m1_read | m1_write;
        grant_valid = ~reset & (req0 | req1);
        // When idle the mux parks on the last granted master; strobes are gated anyway.
        grant_id    = last_grant;
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_id = ~last_grant;
`else
            grant_id = 1'b0;
`endif
        end else if (req0) begin
            grant_id = 1'b0;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

    always_comb begin
        s_address    = grant_id ? m1_address    : m0_address;
        s_byteenable = grant_id ? m1_byteenable : m0_byteenable;
        s_writedata  = grant_id ? m1_writedata  : m0_writedata;
        sel_read     = grant_id ? m1_read       : m0_read;
        sel_write    = grant_id ? m1_write      : m0_write;
        // Write wins when a master raises read and write together.
        s_write      = grant_valid & sel_write;
        s_read       = grant_valid & sel_read & ~sel_write;
    end

    assign m0_waitrequest = reset | (req0 & grant_id);
    assign m1_waitrequest = reset | (req1 & ~grant_id);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
            tag_valid  <= 1'b0;
            tag_id     <= 1'b0;
        end else begin
            if (grant_valid) begin
                last_grant <= grant_id;
            end
            tag_valid <= s_read;
            tag_id    <= grant_id;
        end
    end

    // Reset also masks a response already in flight.
    assign m0_readdatavalid = tag_valid & ~reset & ~tag_id;
    assign m1_readdatavalid = tag_valid & ~reset & tag_id;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule
